// File: rtl/any1_pkg.sv
// Shared ANY-1 definitions: opcodes, the core state encoding and instruction field decoders.
package any1_pkg;

    localparam logic [7:0]  NOP      = 8'hEA;
    localparam logic [7:0]  ADDI     = 8'h04;
    localparam logic [7:0]  BEQ      = 8'h26;
    localparam logic [7:0]  STX      = 8'h70;
    localparam logic [31:0] NOP_INSN = 32'h000000EA;

    typedef enum logic [1:0] {
        IFETCH,
        IWAIT,
        EXEC,
        DSTORE
    } state_e;

    function automatic logic [7:0] f_opcode(input logic [31:0] ir);
        return ir[7:0];
    endfunction

    function automatic logic [5:0] f_rt(input logic [31:0] ir);
        return ir[13:8];
    endfunction

    function automatic logic [5:0] f_ra(input logic [31:0] ir);
        return ir[19:14];
    endfunction

    function automatic logic [5:0] f_rb(input logic [31:0] ir);
        return ir[25:20];
    endfunction

    function automatic logic [63:0] f_imm12(input logic [31:0] ir);
        return {{52{ir[31]}}, ir[31:20]};
    endfunction

    // Branch/store displacement is split around the Ra/Rb fields.
    function automatic logic [31:0] f_disp12(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:26], ir[13:8]};
    endfunction

endpackage

// File: rtl/any1_regfile.sv
// 64 x 64-bit general register file: two combinational read ports, one write port, r0 reads zero.
module any1_regfile (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [5:0]  ra_i,
    input  logic [5:0]  rb_i,
    output logic [63:0] ra_o,
    output logic [63:0] rb_o,
    input  logic        we_i,
    input  logic [5:0]  wa_i,
    input  logic [63:0] wd_i
);

    logic [63:0] regs_q [64];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 64; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != 6'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign ra_o = (ra_i == 6'd0) ? 64'd0 : regs_q[ra_i];
    assign rb_o = (rb_i == 6'd0) ? 64'd0 : regs_q[rb_i];

endmodule

// File: rtl/any1_oo.sv
// Minimal in-order multi-cycle ANY-1 core with one 128-bit classic bus master.
// Build option ANY1_FETCH_BUF_EN: reuse the latched bundle when the next pc stays inside it.
module any1_oo
    import any1_pkg::*;
#(
    parameter logic [31:0] RSTVEC = 32'hFFFC0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wc_clk_i,
    input  logic         nmi_i,
    input  logic         irq_i,
    input  logic [7:0]   cause_i,
    output logic         vpa_o,
    output logic         cyc_o,
    output logic         stb_o,
    input  logic         ack_i,
    output logic         we_o,
    output logic [15:0]  sel_o,
    output logic [31:0]  adr_o,
    input  logic [127:0] dat_i,
    output logic [127:0] dat_o
);

    state_e        state_q;
    logic [31:0]   pc_q;
    logic [127:0]  bundle_q;
    logic          cyc_q;
    logic          vpa_q;
    logic          we_q;
    logic [15:0]   sel_q;
    logic [31:0]   adr_q;
    logic [127:0]  dat_q;
`ifdef ANY1_FETCH_BUF_EN
    logic          buf_vld_q;
    logic [27:0]   buf_tag_q;
`endif

    logic [31:0]   ir_d;
    logic [7:0]    op_d;
    logic [63:0]   ra_data;
    logic [63:0]   rb_data;
    logic [31:0]   pc_next_d;
    logic [31:0]   st_adr_d;
    logic          unused_inputs;

    assign unused_inputs = ^{wc_clk_i, nmi_i, irq_i, cause_i};

    assign ir_d = bundle_q[{pc_q[3:2], 5'b00000} +: 32];
    assign op_d = f_opcode(ir_d);

    any1_regfile u_rf (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .ra_i   (f_ra(ir_d)),
        .rb_i   (f_rb(ir_d)),
        .ra_o   (ra_data),
        .rb_o   (rb_data),
        .we_i   ((state_q == EXEC) && (op_d == ADDI)),
        .wa_i   (f_rt(ir_d)),
        .wd_i   (ra_data + f_imm12(ir_d))
    );

    always_comb begin
        pc_next_d = pc_q + 32'd4;
        if ((op_d == BEQ) && (ra_data == rb_data)) pc_next_d = pc_q + f_disp12(ir_d);
    end

    assign st_adr_d = (ra_data[31:0] + f_disp12(ir_d)) & 32'hFFFF_FFF8;

    // Bus cycles only start once ack_i is seen low, so a trailing ack is never reused.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IFETCH;
            pc_q     <= RSTVEC;
            bundle_q <= {4{NOP_INSN}};
            cyc_q    <= 1'b0;
            vpa_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
`ifdef ANY1_FETCH_BUF_EN
            buf_vld_q <= 1'b0;
            buf_tag_q <= '0;
`endif
        end else begin
            case (state_q)
                IFETCH: begin
                    if (!ack_i) begin
                        cyc_q   <= 1'b1;
                        vpa_q   <= 1'b1;
                        we_q    <= 1'b0;
                        sel_q   <= 16'hFFFF;
                        adr_q   <= {pc_q[31:4], 4'h0};
                        state_q <= IWAIT;
                    end
                end
                IWAIT: begin
                    if (ack_i) begin
                        bundle_q <= dat_i;
                        cyc_q    <= 1'b0;
                        vpa_q    <= 1'b0;
                        state_q  <= EXEC;
`ifdef ANY1_FETCH_BUF_EN
                        buf_vld_q <= 1'b1;
                        buf_tag_q <= pc_q[31:4];
`endif
                    end
                end
                EXEC: begin
                    pc_q <= pc_next_d;
                    if (op_d == STX) begin
                        adr_q   <= st_adr_d;
                        dat_q   <= {rb_data, rb_data};
                        sel_q   <= st_adr_d[3] ? 16'hFF00 : 16'h00FF;
                        state_q <= DSTORE;
`ifdef ANY1_FETCH_BUF_EN
                        if (st_adr_d[31:4] == buf_tag_q) buf_vld_q <= 1'b0;
`endif
                    end else begin
`ifdef ANY1_FETCH_BUF_EN
                        state_q <= (buf_vld_q && (pc_next_d[31:4] == buf_tag_q)) ? EXEC : IFETCH;
`else
                        state_q <= IFETCH;
`endif
                    end
                end
                DSTORE: begin
                    if (!cyc_q) begin
                        if (!ack_i) begin
                            cyc_q <= 1'b1;
                            we_q  <= 1'b1;
                            vpa_q <= 1'b0;
                        end
                    end else if (ack_i) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= IFETCH;
                    end
                end
                default: state_q <= IFETCH;
            endcase
        end
    end

    assign cyc_o = cyc_q;
    assign stb_o = cyc_q;
    assign vpa_o = vpa_q;
    assign we_o  = we_q;
    assign sel_o = sel_q;
    assign adr_o = adr_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_any1_oo.sv
// Directed bench for any1_oo: small ROM image, bus responder with optional trailing ack.
module tb_any1_oo;

    localparam logic [31:0] I_NOP   = 32'h000000EA;
    localparam logic [31:0] I_ADDI4 = 32'h00110404;  // ADDI r4,r4,1
    localparam logic [31:0] I_ADDI6 = 32'h0021C604;  // ADDI r6,r7,2
    localparam logic [31:0] I_STO6  = 32'h00600070;  // STO r6,0(r0)
    localparam logic [31:0] I_BEQ4  = 32'hFC410026;  // BEQ r4,r4,-64

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         ack_i = 1'b0;
    logic [127:0] dat_i = '0;
    logic         vpa_o, cyc_o, stb_o, we_o;
    logic [15:0]  sel_o;
    logic [31:0]  adr_o;
    logic [127:0] dat_o;

    int tests = 0;
    int fails = 0;
    int trail = 0;
    int hold  = 0;
    int viol  = 0;
    logic cyc_prev = 1'b0;

    logic [31:0]  fetch_q [$];
    logic [31:0]  st_adr_q [$];
    logic [15:0]  st_sel_q [$];
    logic [127:0] st_dat_q [$];
    logic [1:0]   st_wv_q [$];

    always #5 clk_i = ~clk_i;

    any1_oo dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wc_clk_i (clk_i),
        .nmi_i    (1'b0),
        .irq_i    (1'b0),
        .cause_i  (8'h00),
        .vpa_o    (vpa_o),
        .cyc_o    (cyc_o),
        .stb_o    (stb_o),
        .ack_i    (ack_i),
        .we_o     (we_o),
        .sel_o    (sel_o),
        .adr_o    (adr_o),
        .dat_i    (dat_i),
        .dat_o    (dat_o)
    );

    function automatic logic [127:0] rom(input logic [31:0] a);
        case (a)
            32'hFFFC0000: rom = {I_ADDI4, I_NOP, I_NOP, I_NOP};
            32'hFFFC0010: rom = {4{I_ADDI6}};
            32'hFFFC0020: rom = {4{I_STO6}};
            32'hFFFC0040: rom = {I_NOP, I_NOP, I_NOP, I_BEQ4};
            default:      rom = {4{I_NOP}};
        endcase
    endfunction

    // Bus slave: acks half a cycle after a request, optionally holding ack for extra cycles.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                ack_i = 1'b0;
                hold  = 0;
            end else if (ack_i) begin
                if (hold > 0) hold--;
                else ack_i = 1'b0;
            end else if (cyc_o && stb_o) begin
                ack_i = 1'b1;
                hold  = trail;
                if (we_o) begin
                    st_adr_q.push_back(adr_o);
                    st_sel_q.push_back(sel_o);
                    st_dat_q.push_back(dat_o);
                    st_wv_q.push_back({we_o, vpa_o});
                end else begin
                    fetch_q.push_back(adr_o);
                    dat_i = rom(adr_o);
                end
            end
        end
    end

    // A cycle starting at an edge where ack_i was still high breaks the bus rule.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (cyc_o && !cyc_prev && ack_i) viol++;
            cyc_prev = cyc_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fetches(input int n, input string tag);
        int k = 0;
        while (fetch_q.size() < n && k < 3000) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check({tag, "_timeout"}, 128'(fetch_q.size() >= n), 128'd1);
    endtask

    task automatic wait_stores(input int n, input string tag);
        int k = 0;
        while (st_adr_q.size() < n && k < 3000) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check({tag, "_timeout"}, 128'(st_adr_q.size() >= n), 128'd1);
    endtask

    task automatic wait_cyc(input logic lvl, input string tag);
        int k = 0;
        while (cyc_o !== lvl && k < 200) begin
            @(posedge clk_i);
            #1;
            k++;
        end
        check({tag, "_timeout"}, 128'(cyc_o === lvl), 128'd1);
    endtask

    initial begin
        int nf;
        rst_i = 1'b1;
        #1 rst_i = 1'b0;

        repeat (4) begin
            @(negedge clk_i);
            check("rst_cyc", cyc_o, 1'b0);
        end
        check("rst_ctl", {vpa_o, stb_o, we_o}, 3'b000);
        check("rst_sel", sel_o, 16'h0000);
        check("rst_adr", adr_o, 32'h0);
        check("rst_dat", dat_o, 128'h0);
        check("rst_r4", dut.u_rf.regs_q[4], 64'd0);
        check("rst_fetches", 128'(fetch_q.size()), 128'd0);

        @(negedge clk_i);
        rst_i = 1'b1;
        wait_cyc(1'b1, "first_fetch");
        check("first_adr", adr_o, 32'hFFFC0000);
        check("first_sel", sel_o, 16'hFFFF);
        check("first_ctl", {vpa_o, cyc_o, stb_o, we_o}, 4'b1110);

        wait_fetches(5, "b0");
        check("b0_slot3_fetch", fetch_q[3], 32'hFFFC0000);
        check("b1_fetch", fetch_q[4], 32'hFFFC0010);
        check("r4_pass1", dut.u_rf.regs_q[4], 64'd1);

        wait_stores(4, "sto");
        check("r6", dut.u_rf.regs_q[6], 64'd2);
        for (int i = 0; i < 4; i++) begin
            check("sto_adr", st_adr_q[i], 32'h0);
            check("sto_sel", st_sel_q[i], 16'h00FF);
            check("sto_dat", st_dat_q[i], {64'd2, 64'd2});
            check("sto_we_vpa", st_wv_q[i], 2'b10);
        end

        wait_fetches(18, "beq");
        check("b2_fetch", fetch_q[8], 32'hFFFC0020);
        check("beq_fetch", fetch_q[16], 32'hFFFC0040);
        check("beq_target", fetch_q[17], 32'hFFFC0000);

        wait_fetches(22, "pass2");
        check("r4_pass2", dut.u_rf.regs_q[4], 64'd2);

        trail = 2;
        wait_fetches(30, "trail");
        check("trail_store_count", 128'(st_adr_q.size()), 128'd8);
        check("trail_b3_fetch", fetch_q[29], 32'hFFFC0030);
        for (int i = 4; i < 8; i++) begin
            check("trail_sto_adr", st_adr_q[i], 32'h0);
            check("trail_sto_sel", st_sel_q[i], 16'h00FF);
            check("trail_sto_dat", st_dat_q[i], {64'd2, 64'd2});
        end
        check("bus_rule", 128'(viol), 128'd0);

        trail = 0;
        wait_cyc(1'b0, "idle");
        wait_cyc(1'b1, "iwait");
        check("iwait_is_fetch", vpa_o, 1'b1);
        rst_i = 1'b0;
        #1;
        check("midrst_ctl", {vpa_o, cyc_o, stb_o, we_o}, 4'b0000);
        check("midrst_r4", dut.u_rf.regs_q[4], 64'd0);
        check("midrst_r6", dut.u_rf.regs_q[6], 64'd0);
        nf = fetch_q.size();
        repeat (4) @(negedge clk_i);
        check("midrst_quiet", 128'(fetch_q.size()), 128'(nf));
        check("midrst_cyc", cyc_o, 1'b0);
        rst_i = 1'b1;
        wait_cyc(1'b1, "refetch");
        check("refetch_adr", adr_o, 32'hFFFC0000);
        wait_fetches(nf + 5, "rerun");
        check("rerun_b1", fetch_q[nf + 4], 32'hFFFC0010);
        check("rerun_r4", dut.u_rf.regs_q[4], 64'd1);
        check("bus_rule_end", 128'(viol), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
